pilha_dados: RTL and testbench

PILHA_DADOS -- requirements
Module: pilha_dados

---
 rtl/pilha_pkg.sv | 15 +
 rtl/pilha_mem.sv | 26 ++
 rtl/pilha_dados.sv | 116 +++++++++++
 tb/tb_pilha_dados.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pilha_pkg.sv
// pilha_pkg: shared defaults, push-source encoding and FSM state type for the data stack.
package pilha_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 16;

  localparam logic SRC_DADO = 1'b0;
  localparam logic SRC_ULA  = 1'b1;

  typedef enum logic {
    OPERA = 1'b0,
    ERRO  = 1'b1
  } estado_t;

endpackage

// File: rtl/pilha_mem.sv
// pilha_mem: DEPTH x WIDTH register array; write takes effect on the clock edge, read is combinational.
module pilha_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents survive reset on purpose; the level counter decides what is valid.
  always_ff @(posedge clock_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pilha_dados.sv
// pilha_dados: LIFO data stack; pop result registered (latency 1), no backpressure, overflow/underflow flagged on erro.
// Build with PILHA_ERRO_STICKY_EN to latch errors and ignore every operation until reset.
module pilha_dados
  import pilha_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             op_en,
  input  logic             wren,
  input  logic             controle,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] ula_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_out_valid,
  output logic [WIDTH-1:0] topo,
  output logic [LW-1:0]    nivel,
  output logic             cheia,
  output logic             vazia,
  output logic             erro
);

  estado_t          estado_q, estado_d;
  logic [LW-1:0]    nivel_q, nivel_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             vld_q, vld_d;
  logic             erro_q, erro_d;
  logic             arm_q;

  logic             cheia_w, vazia_w;
  logic             op_ok, do_push, do_pop, falha;
  logic [AW-1:0]    top_addr;
  logic [WIDTH-1:0] rd_dat, push_dat;

  assign cheia_w  = (nivel_q == LW'(DEPTH));
  assign vazia_w  = (nivel_q == '0);
  // arm_q swallows any strobe on the first edge after reset release.
  assign op_ok    = op_en && arm_q && (estado_q == OPERA);
  assign do_push  = op_ok && wren && !cheia_w;
  assign do_pop   = op_ok && !wren && !vazia_w;
  assign falha    = op_ok && (wren ? cheia_w : vazia_w);
  assign top_addr = nivel_q[AW-1:0] - AW'(1);
  assign push_dat = (controle == SRC_ULA) ? ula_in : data_in;

  pilha_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clock_i (clock),
    .we_i    (do_push),
    .waddr_i (nivel_q[AW-1:0]),
    .wdata_i (push_dat),
    .raddr_i (top_addr),
    .rdata_o (rd_dat)
  );

  always_comb begin
    estado_d = estado_q;
    nivel_d  = nivel_q;
    dout_d   = dout_q;
    vld_d    = 1'b0;
    if (do_push) begin
      nivel_d = nivel_q + LW'(1);
    end
    if (do_pop) begin
      nivel_d = nivel_q - LW'(1);
      dout_d  = rd_dat;
      vld_d   = 1'b1;
    end
`ifdef PILHA_ERRO_STICKY_EN
    erro_d = erro_q | falha;
`else
    erro_d = falha;
`endif
    case (estado_q)
      OPERA: begin
`ifdef PILHA_ERRO_STICKY_EN
        if (falha) estado_d = ERRO;
`endif
      end
      ERRO:    estado_d = ERRO;
      default: estado_d = OPERA;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= OPERA;
      nivel_q  <= '0;
      dout_q   <= '0;
      vld_q    <= 1'b0;
      erro_q   <= 1'b0;
      arm_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      nivel_q  <= nivel_d;
      dout_q   <= dout_d;
      vld_q    <= vld_d;
      erro_q   <= erro_d;
      arm_q    <= 1'b1;
    end
  end

  assign data_out       = dout_q;
  assign data_out_valid = vld_q;
  assign topo           = vazia_w ? '0 : rd_dat;
  assign nivel          = nivel_q;
  assign cheia          = cheia_w;
  assign vazia          = vazia_w;
  assign erro           = erro_q;

endmodule

// File: tb/tb_pilha_dados.sv
// Bench for pilha_dados: vector table, hand-written corner sequences, randomized run against a queue model.
module tb_pilha_dados;

`ifdef PILHA_ERRO_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif
  localparam int DEPTH = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       op_en = 1'b0, wren = 1'b0, controle = 1'b0;
  logic [7:0] data_in = '0, ula_in = '0;
  logic [7:0] data_out, topo;
  logic       data_out_valid, cheia, vazia, erro;
  logic [4:0] nivel;

  int n_cmp = 0;
  int n_bad = 0;

  pilha_dados dut (
    .clock(clock), .reset(reset), .op_en(op_en), .wren(wren), .controle(controle),
    .data_in(data_in), .ula_in(ula_in), .data_out(data_out),
    .data_out_valid(data_out_valid), .topo(topo), .nivel(nivel),
    .cheia(cheia), .vazia(vazia), .erro(erro)
  );

  always #5 clock = ~clock;

  // Reference model: stack contents as a queue plus last popped value and error state.
  logic [7:0] stk[$];
  logic [7:0] m_dout;
  bit         m_vld, m_err, m_dead;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit en, input bit wr, input bit ctl, input logic [7:0] d, input logic [7:0] u);
    op_en = en; wren = wr; controle = ctl; data_in = d; ula_in = u;
  endtask

  function automatic void model_reset();
    stk.delete();
    m_dout = 8'h00; m_vld = 0; m_err = 0; m_dead = 0;
  endfunction

  function automatic void model_step(input bit en, input bit wr, input bit ctl, input logic [7:0] d, input logic [7:0] u);
    bit bad = 0;
    m_vld = 0;
    if (en && !m_dead) begin
      if (wr) begin
        if (stk.size() == DEPTH) bad = 1;
        else stk.push_back(ctl ? u : d);
      end else begin
        if (stk.size() == 0) bad = 1;
        else begin m_dout = stk.pop_back(); m_vld = 1; end
      end
    end
    if (STICKY) begin
      if (bad) m_dead = 1;
      m_err = m_dead;
    end else begin
      m_err = bad;
    end
  endfunction

  task automatic check_model(input string tag);
    chk({tag, "_nivel"}, nivel, stk.size());
    chk({tag, "_topo"}, topo, (stk.size() == 0) ? 8'h00 : stk[$]);
    chk({tag, "_cheia"}, cheia, stk.size() == DEPTH);
    chk({tag, "_vazia"}, vazia, stk.size() == 0);
    chk({tag, "_dout"}, data_out, m_dout);
    chk({tag, "_vld"}, data_out_valid, m_vld);
    chk({tag, "_erro"}, erro, m_err);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 8'h00, 8'h00);
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    tick();
    model_reset();
  endtask

  typedef struct {
    bit         en, wr, ctl;
    logic [7:0] d, u;
    int         e_nivel;
    logic [7:0] e_topo, e_dout;
    bit         e_vld;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1, 1, 0, 8'h11, 8'h00, 1, 8'h11, 8'h00, 0};
    tbl[1]  = '{1, 1, 0, 8'h22, 8'h00, 2, 8'h22, 8'h00, 0};
    tbl[2]  = '{1, 1, 0, 8'h33, 8'h00, 3, 8'h33, 8'h00, 0};
    tbl[3]  = '{1, 0, 0, 8'h00, 8'h00, 2, 8'h22, 8'h33, 1};
    tbl[4]  = '{1, 0, 0, 8'h00, 8'h00, 1, 8'h11, 8'h22, 1};
    tbl[5]  = '{1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h11, 1};
    tbl[6]  = '{0, 1, 1, 8'h44, 8'h44, 0, 8'h00, 8'h11, 0};
    tbl[7]  = '{1, 1, 1, 8'h5A, 8'hA5, 1, 8'hA5, 8'h11, 0};
    tbl[8]  = '{1, 1, 0, 8'h5A, 8'hA5, 2, 8'h5A, 8'h11, 0};
    tbl[9]  = '{1, 0, 1, 8'h00, 8'h00, 1, 8'hA5, 8'h5A, 1};
    tbl[10] = '{1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'hA5, 1};

    // Reset values are visible while reset is still held, before any edge.
    #2;
    chk("rst_nivel", nivel, 0);
    chk("rst_vazia", vazia, 1);
    chk("rst_cheia", cheia, 0);
    chk("rst_dout", data_out, 8'h00);
    chk("rst_vld", data_out_valid, 0);
    chk("rst_erro", erro, 0);
    do_reset();

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].en, tbl[i].wr, tbl[i].ctl, tbl[i].d, tbl[i].u);
      tick();
      chk($sformatf("tbl%0d_nivel", i), nivel, tbl[i].e_nivel);
      chk($sformatf("tbl%0d_topo", i), topo, tbl[i].e_topo);
      chk($sformatf("tbl%0d_dout", i), data_out, tbl[i].e_dout);
      chk($sformatf("tbl%0d_vld", i), data_out_valid, tbl[i].e_vld);
      chk($sformatf("tbl%0d_erro", i), erro, 0);
    end

    // Underflow right after reset.
    do_reset();
    drive(1, 0, 0, 8'h00, 8'h00); tick();
    chk("udf_vld", data_out_valid, 0);
    chk("udf_dout", data_out, 8'h00);
    chk("udf_nivel", nivel, 0);
    chk("udf_erro", erro, 1);
    drive(0, 0, 0, 8'h00, 8'h00); tick();
    chk("udf_erro_after", erro, STICKY);
    drive(1, 1, 0, 8'h01, 8'h00); tick();
    chk("udf_push_nivel", nivel, STICKY ? 0 : 1);
    chk("udf_push_topo", topo, STICKY ? 8'h00 : 8'h01);

    // Fill to capacity, then overflow.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 1, 0, 8'(i + 1), 8'h00); tick();
    end
    chk("full_nivel", nivel, DEPTH);
    chk("full_cheia", cheia, 1);
    chk("full_topo", topo, 8'h10);
    chk("full_erro", erro, 0);
    drive(1, 1, 0, 8'hFF, 8'h00); tick();
    chk("ovf_nivel", nivel, DEPTH);
    chk("ovf_cheia", cheia, 1);
    chk("ovf_topo", topo, 8'h10);
    chk("ovf_erro", erro, 1);
    drive(0, 0, 0, 8'h00, 8'h00); tick();
    chk("ovf_erro_after", erro, STICKY);
    drive(1, 0, 0, 8'h00, 8'h00); tick();
    chk("ovf_pop_vld", data_out_valid, !STICKY);
    chk("ovf_pop_dout", data_out, STICKY ? 8'h00 : 8'h10);
    chk("ovf_pop_nivel", nivel, STICKY ? DEPTH : DEPTH - 1);

    // Asynchronous reset in the middle of a cycle.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 8'h07, 8'h00); tick();
    end
    drive(1, 0, 0, 8'h00, 8'h00); tick();
    chk("mid_pre_dout", data_out, 8'h07);
    chk("mid_pre_nivel", nivel, 4);
    drive(0, 0, 0, 8'h00, 8'h00);
    @(posedge clock); #3;
    reset = 1'b0;
    #1;
    chk("mid_nivel", nivel, 0);
    chk("mid_vazia", vazia, 1);
    chk("mid_dout", data_out, 8'h00);
    chk("mid_vld", data_out_valid, 0);

    // A strobe on the first edge after reset release is ignored.
    drive(1, 1, 0, 8'h99, 8'h00);
    @(posedge clock); #7;
    reset = 1'b1;
    tick();
    chk("rel_nivel", nivel, 0);
    tick();
    chk("rel_next_nivel", nivel, 1);
    chk("rel_next_topo", topo, 8'h99);

    // Randomized run, with blocks biased toward filling or draining.
    for (int b = 0; b < 4; b++) begin
      int pw;
      pw = (b == 0) ? 70 : (b == 1) ? 30 : (b == 2) ? 55 : 85;
      do_reset();
      for (int c = 0; c < 80; c++) begin
        bit en, wr, ctl;
        logic [7:0] d, u;
        en  = ($urandom_range(0, 99) < 80);
        wr  = ($urandom_range(0, 99) < pw);
        ctl = $urandom_range(0, 1);
        d   = 8'($urandom);
        u   = 8'($urandom);
        drive(en, wr, ctl, d, u);
        model_step(en, wr, ctl, d, u);
        tick();
        check_model($sformatf("rnd%0d_%0d", b, c));
      end
    end

    drive(0, 0, 0, 8'h00, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
